// File: rtl/miter_seq_checker.sv
//==============================================================================
// Module   : miter_seq_checker
// Purpose  : Sequential gold/gate miter checker. Tracks the first divergence,
//            counts mismatches and holds a sticky verdict.
//            Optional macro MITER_STOP_ON_FAIL_EN ends the run on the first
//            counted mismatch.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module miter_seq_checker #(
  parameter int WIDTH  = 1,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             valid,
  input  logic [WIDTH-1:0] in_gold,
  input  logic [WIDTH-1:0] in_gate,
  input  logic [WIDTH-1:0] in_gold_x,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] first_fail_cycle,
  output logic [WIDTH-1:0] first_fail_bits
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam state_t     c_START_STATE = (SETTLE == 0) ? S_RUN : S_SETTLE;
  localparam logic [7:0] c_SETTLE_LAST = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_settle_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_fail;
  logic [CNT_W-1:0] r_mismatch_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_first_fail_cycle;
  logic [WIDTH-1:0] r_first_fail_bits;

  logic [WIDTH-1:0] w_mm;
  logic             w_mismatch;
  logic             w_count;

  assign w_mm       = ~in_gold_x & (in_gold ^ in_gate);
  assign w_mismatch = |w_mm;
  // A sample is counted only in RUN; a coincident start discards it.
  assign w_count    = (r_state == S_RUN) && valid && !start;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = c_START_STATE;
      end
      S_SETTLE: begin
        if (start)                                      w_next = c_START_STATE;
        else if (stop)                                  w_next = S_DONE;
        else if (valid && r_settle_cnt == c_SETTLE_LAST) w_next = S_RUN;
      end
      S_RUN: begin
        if (start)     w_next = c_START_STATE;
        else if (stop) w_next = S_DONE;
`ifdef MITER_STOP_ON_FAIL_EN
        else if (valid && w_mismatch) w_next = S_DONE;
`endif
      end
      S_DONE: begin
        if (start) w_next = c_START_STATE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_SETTLE) || (w_next == S_RUN);
      r_done  <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_settle_cnt <= 8'd0;
    end else if (start) begin
      r_settle_cnt <= 8'd0;
    end else if (r_state == S_SETTLE && valid) begin
      r_settle_cnt <= r_settle_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fail             <= 1'b0;
      r_mismatch_cnt     <= '0;
      r_cycle_cnt        <= '0;
      r_first_fail_cycle <= '0;
      r_first_fail_bits  <= '0;
    end else if (start) begin
      r_fail             <= 1'b0;
      r_mismatch_cnt     <= '0;
      r_cycle_cnt        <= '0;
      r_first_fail_cycle <= '0;
      r_first_fail_bits  <= '0;
    end else if (w_count) begin
      if (r_cycle_cnt != {CNT_W{1'b1}}) r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_mismatch) begin
        r_fail <= 1'b1;
        if (r_mismatch_cnt != {CNT_W{1'b1}}) r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
        if (!r_fail) begin
          r_first_fail_cycle <= r_cycle_cnt;
          r_first_fail_bits  <= w_mm;
        end
      end
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign fail             = r_fail;
  assign mismatch_cnt     = r_mismatch_cnt;
  assign cycle_cnt        = r_cycle_cnt;
  assign first_fail_cycle = r_first_fail_cycle;
  assign first_fail_bits  = r_first_fail_bits;

endmodule

`default_nettype wire

// File: tb/tb_miter_seq_checker.sv
//==============================================================================
// Module   : tb_miter_seq_checker
// Purpose  : Directed self-checking bench for miter_seq_checker.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_miter_seq_checker;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       valid;
  logic [3:0] in_gold;
  logic [3:0] in_gate;
  logic [3:0] in_gold_x;

  logic        busy, done, fail;
  logic [15:0] mismatch_cnt, cycle_cnt, first_fail_cycle;
  logic [3:0]  first_fail_bits;

  logic        s_busy, s_done, s_fail;
  logic [3:0]  s_mismatch_cnt, s_cycle_cnt, s_first_fail_cycle;
  logic [3:0]  s_first_fail_bits;

  int n_checks = 0;
  int n_fails  = 0;

  miter_seq_checker #(.WIDTH(4), .CNT_W(16), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .valid(valid),
    .in_gold(in_gold), .in_gate(in_gate), .in_gold_x(in_gold_x),
    .busy(busy), .done(done), .fail(fail),
    .mismatch_cnt(mismatch_cnt), .cycle_cnt(cycle_cnt),
    .first_fail_cycle(first_fail_cycle), .first_fail_bits(first_fail_bits)
  );

  miter_seq_checker #(.WIDTH(4), .CNT_W(4), .SETTLE(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .valid(valid),
    .in_gold(in_gold), .in_gate(in_gate), .in_gold_x(in_gold_x),
    .busy(s_busy), .done(s_done), .fail(s_fail),
    .mismatch_cnt(s_mismatch_cnt), .cycle_cnt(s_cycle_cnt),
    .first_fail_cycle(s_first_fail_cycle), .first_fail_bits(s_first_fail_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic v, input logic [3:0] g, input logic [3:0] t,
                     input logic [3:0] x, input logic st, input logic sp);
    valid = v; in_gold = g; in_gate = t; in_gold_x = x; start = st; stop = sp;
    @(posedge clk);
    #1;
    valid = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; valid = 1'b0;
    in_gold = '0; in_gate = '0; in_gold_x = '0;
    #1;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_fail", 32'(fail), 0);
    check("reset_cycle", 32'(cycle_cnt), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Clean run: 10 matching samples, 2 swallowed by settle.
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    check("clean_busy_after_start", 32'(busy), 1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 4'(i), 4'(i), 4'h0, 1'b0, 1'b0);
    check("clean_busy_running", 32'(busy), 1);
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    check("clean_done", 32'(done), 1);
    check("clean_busy", 32'(busy), 0);
    check("clean_fail", 32'(fail), 0);
    check("clean_cycle", 32'(cycle_cnt), 8);
    check("clean_mm", 32'(mismatch_cnt), 0);

    // X masking: every differing gold bit is don't-care.
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    check("xmask_cleared_cycle", 32'(cycle_cnt), 0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'hF, 4'h0, 4'hF, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    check("xmask_fail", 32'(fail), 0);
    check("xmask_mm", 32'(mismatch_cnt), 0);
    check("xmask_cycle", 32'(cycle_cnt), 6);

    // First failure capture; settle samples mismatch but must be ignored.
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    cyc(1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    check("settle_ignored_fail", 32'(fail), 0);
    cyc(1'b1, 4'h3, 4'h3, 4'h0, 1'b0, 1'b0);      // sample 0
    cyc(1'b1, 4'h5, 4'h5, 4'h2, 1'b0, 1'b0);      // sample 1
    cyc(1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);      // idle cycle, no effect
    check("novalid_cycle", 32'(cycle_cnt), 2);
    check("novalid_fail", 32'(fail), 0);
    cyc(1'b1, 4'h9, 4'h9, 4'h0, 1'b0, 1'b0);      // sample 2
    cyc(1'b1, 4'b0110, 4'b0010, 4'b0001, 1'b0, 1'b0); // sample 3, mm=0100
    check("ff_fail_s3", 32'(fail), 1);
    check("ff_cycle_s3", 32'(first_fail_cycle), 3);
    check("ff_bits_s3", 32'(first_fail_bits), 32'h4);
    check("ff_mm_s3", 32'(mismatch_cnt), 1);
`ifdef MITER_STOP_ON_FAIL_EN
    check("sof_done_s3", 32'(done), 1);
    check("sof_busy_s3", 32'(busy), 0);
    check("sof_cycle_s3", 32'(cycle_cnt), 4);
`else
    check("ff_busy_s3", 32'(busy), 1);
`endif
    cyc(1'b1, 4'h7, 4'h7, 4'h0, 1'b0, 1'b0);      // sample 4
    cyc(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1); // sample 5 with stop, mm=0001
    check("ff_done", 32'(done), 1);
    check("ff_fcycle", 32'(first_fail_cycle), 3);
    check("ff_fbits", 32'(first_fail_bits), 32'h4);
`ifdef MITER_STOP_ON_FAIL_EN
    check("ff_mm", 32'(mismatch_cnt), 1);
    check("ff_cycle", 32'(cycle_cnt), 4);
`else
    check("ff_mm", 32'(mismatch_cnt), 2);
    check("ff_cycle", 32'(cycle_cnt), 6);
`endif

    // Saturation: 20 mismatching samples.
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 22; i++) cyc(1'b1, 4'h8, 4'h0, 4'h0, 1'b0, 1'b0);
    check("sat_fail", 32'(s_fail), 1);
`ifdef MITER_STOP_ON_FAIL_EN
    check("sat_cycle", 32'(s_cycle_cnt), 1);
    check("sat_mm", 32'(s_mismatch_cnt), 1);
    check("sat_done", 32'(s_done), 1);
`else
    check("sat_cycle", 32'(s_cycle_cnt), 15);
    check("sat_mm", 32'(s_mismatch_cnt), 15);
    check("wide_cycle", 32'(cycle_cnt), 20);
    check("wide_mm", 32'(mismatch_cnt), 20);
    check("sat_fbits", 32'(s_first_fail_bits), 32'h8);
`endif

    // Reset mid-run.
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'h1, 4'h1, 4'h0, 1'b0, 1'b0);
    check("prerst_cycle", 32'(cycle_cnt), 3);
    #2;
    rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cycle", 32'(cycle_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_busy", 32'(busy), 0);

    // Build a failing result in DONE, then start+stop together.
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 4'h2, 4'h0, 4'h0, 1'b0, 1'b1);
    check("pre_restart_done", 32'(done), 1);
    check("pre_restart_fail", 32'(fail), 1);
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    check("restart_busy", 32'(busy), 1);
    check("restart_done", 32'(done), 0);
    check("restart_fail", 32'(fail), 0);
    check("restart_mm", 32'(mismatch_cnt), 0);
    check("restart_fbits", 32'(first_fail_bits), 0);
    cyc(1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    check("restart_in_settle", 32'(cycle_cnt), 0);
    check("restart_settle_fail", 32'(fail), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
